// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerant cv32e40p TMR error controller.
package cv32e40p_ft_pkg;

    localparam int N_REPLICA = 3;

    typedef logic [N_REPLICA-1:0] replica_oh_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FATAL
    } tmr_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_tmr_error_ctrl_if.sv
// Resync handshake between the TMR error controller and the pipeline.
interface cv32e40p_tmr_error_ctrl_if;
    import cv32e40p_ft_pkg::*;

    logic        resync_req_o;
    replica_oh_t resync_replica_o;
    logic        resync_busy_o;
    logic        resync_ack_i;

    modport master (
        output resync_req_o,
        output resync_replica_o,
        output resync_busy_o,
        input  resync_ack_i
    );

    modport slave (
        input  resync_req_o,
        input  resync_replica_o,
        input  resync_busy_o,
        output resync_ack_i
    );

endinterface

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cv32e40p_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_error_ctrl.sv
// Windowed per-replica error counting, resync request handshake and sticky
// fatal latch for a bank of TMR majority voters.
//
// state | meaning
// IDLE  | monitoring; counters and decay window run
// REQ   | resync requested for the latched replica, waiting for ack
// WAIT  | resync in progress, down-counter running
// FATAL | uncorrectable disagreement seen; left only by reset
module cv32e40p_tmr_error_ctrl
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_IN          = 1,
    parameter int CNT_W         = 4,
    parameter int THRESHOLD     = 4,
    parameter int WINDOW        = 1024,
    parameter int RESYNC_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable_i,
    input  logic [N_IN-1:0]                     err_correct_i,
    input  logic [N_IN-1:0]                     err_detect_i,
    input  logic [N_IN-1:0][N_REPLICA-1:0]      mismatch_i,
    cv32e40p_tmr_error_ctrl_if.master           rs,
    output logic                                fatal_o,
    output logic [N_REPLICA-1:0][CNT_W-1:0]     err_cnt_o,
    output logic [7:0]                          resync_cnt_o
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WAIT_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  THR_C     = CNT_W'(THRESHOLD);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESYNC_CYCLES - 1);

    tmr_ctrl_state_e state_q, state_d;
    logic [WIN_W-1:0]  win_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        rcnt_q, rcnt_d;
    replica_oh_t       sel_q, sel_d;
    logic              req_q, busy_q, fatal_q;

    logic        fatal_ev, monitor_on, win_wrap, wait_entry;
    replica_oh_t hit, over, pick, cnt_inc, cnt_clr;

    assign fatal_ev   = enable_i & (|(err_detect_i & ~err_correct_i));
    assign monitor_on = (state_q == ST_IDLE) & enable_i & ~fatal_ev;
    assign win_wrap   = monitor_on & (win_q == WIN_LAST);
    assign wait_entry = (state_q == ST_REQ) & (state_d == ST_WAIT);

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_IN; k++) begin
            hit = hit | (mismatch_i[k] & {N_REPLICA{err_correct_i[k]}});
        end
    end

    assign cnt_inc = monitor_on ? hit : '0;
    assign cnt_clr = {N_REPLICA{win_wrap}} | (wait_entry ? sel_q : '0);

    for (genvar r = 0; r < N_REPLICA; r++) begin : g_cnt
        cv32e40p_sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (cnt_inc[r]),
            .clr (cnt_clr[r]),
            .cnt (err_cnt_o[r])
        );
        assign over[r] = (err_cnt_o[r] >= THR_C);
    end

    // Isolate the lowest set bit so replica 0 wins ties.
    assign pick = over & (~over + 3'd1);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fatal_ev)   state_d = ST_FATAL;
                else if (|over) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (fatal_ev) begin
                    state_d = ST_FATAL;
                end else if (rs.resync_ack_i) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (fatal_ev) begin
                    state_d = ST_FATAL;
                end else if (wait_q == '0) begin
                    state_d = ST_IDLE;
                    if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = ST_FATAL;
        endcase
        sel_d = '0;
        if (state_d == ST_REQ) sel_d = (state_q == ST_IDLE) ? pick : sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            wait_q  <= '0;
            rcnt_q  <= '0;
            sel_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rcnt_q  <= rcnt_d;
            sel_q   <= sel_d;
            req_q   <= (state_d == ST_REQ);
            busy_q  <= (state_d == ST_REQ) || (state_d == ST_WAIT);
            fatal_q <= (state_d == ST_FATAL);
            if (monitor_on) win_q <= win_wrap ? '0 : win_q + 1'b1;
        end
    end

    assign rs.resync_req_o     = req_q;
    assign rs.resync_replica_o = sel_q;
    assign rs.resync_busy_o    = busy_q;
    assign fatal_o             = fatal_q;
    assign resync_cnt_o        = rcnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_error_ctrl.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor
// compares them against three differently parameterised controllers.
module tb_cv32e40p_tmr_error_ctrl;
    import cv32e40p_ft_pkg::*;

    localparam int S_REQ = 0, S_REP = 1, S_BUSY = 2, S_FATAL = 3;
    localparam int S_CNT0 = 4, S_CNT1 = 5, S_CNT2 = 6, S_RCNT = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: N_IN=2, THR=4, WINDOW=1024
    logic             rst_a, en_a;
    logic [1:0]       corr_a, det_a;
    logic [1:0][2:0]  mm_a;
    logic             fatal_a;
    logic [2:0][3:0]  cnt_a;
    logic [7:0]       rcnt_a;
    // DUT B: N_IN=1, THR=15, WINDOW=8
    logic             rst_b, en_b;
    logic [0:0]       corr_b, det_b;
    logic [0:0][2:0]  mm_b;
    logic             fatal_b;
    logic [2:0][3:0]  cnt_b;
    logic [7:0]       rcnt_b;
    // DUT C: N_IN=1, THR=15, WINDOW=1024
    logic             rst_c, en_c;
    logic [0:0]       corr_c, det_c;
    logic [0:0][2:0]  mm_c;
    logic             fatal_c;
    logic [2:0][3:0]  cnt_c;
    logic [7:0]       rcnt_c;

    cv32e40p_tmr_error_ctrl_if ifa ();
    cv32e40p_tmr_error_ctrl_if ifb ();
    cv32e40p_tmr_error_ctrl_if ifc ();

    cv32e40p_tmr_error_ctrl #(.N_IN(2), .CNT_W(4), .THRESHOLD(4), .WINDOW(1024), .RESYNC_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst_a), .enable_i(en_a), .err_correct_i(corr_a), .err_detect_i(det_a),
        .mismatch_i(mm_a), .rs(ifa), .fatal_o(fatal_a), .err_cnt_o(cnt_a), .resync_cnt_o(rcnt_a));

    cv32e40p_tmr_error_ctrl #(.N_IN(1), .CNT_W(4), .THRESHOLD(15), .WINDOW(8), .RESYNC_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst_b), .enable_i(en_b), .err_correct_i(corr_b), .err_detect_i(det_b),
        .mismatch_i(mm_b), .rs(ifb), .fatal_o(fatal_b), .err_cnt_o(cnt_b), .resync_cnt_o(rcnt_b));

    cv32e40p_tmr_error_ctrl #(.N_IN(1), .CNT_W(4), .THRESHOLD(15), .WINDOW(1024), .RESYNC_CYCLES(16)) dut_c (
        .clk(clk), .rst(rst_c), .enable_i(en_c), .err_correct_i(corr_c), .err_detect_i(det_c),
        .mismatch_i(mm_c), .rs(ifc), .fatal_o(fatal_c), .err_cnt_o(cnt_c), .resync_cnt_o(rcnt_c));

    typedef struct packed {
        int cyc;
        int dut;
        int sig;
        int expv;
        int id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    function automatic int get_sig(int dut, int sig);
        logic       req, busy, fatal;
        logic [2:0] rep;
        logic [2:0][3:0] cnt;
        logic [7:0] rcnt;
        case (dut)
            0: begin req = ifa.resync_req_o; rep = ifa.resync_replica_o; busy = ifa.resync_busy_o;
                     fatal = fatal_a; cnt = cnt_a; rcnt = rcnt_a; end
            1: begin req = ifb.resync_req_o; rep = ifb.resync_replica_o; busy = ifb.resync_busy_o;
                     fatal = fatal_b; cnt = cnt_b; rcnt = rcnt_b; end
            default: begin req = ifc.resync_req_o; rep = ifc.resync_replica_o; busy = ifc.resync_busy_o;
                     fatal = fatal_c; cnt = cnt_c; rcnt = rcnt_c; end
        endcase
        case (sig)
            S_REQ:   return int'(req);
            S_REP:   return int'(rep);
            S_BUSY:  return int'(busy);
            S_FATAL: return int'(fatal);
            S_CNT0:  return int'(cnt[0]);
            S_CNT1:  return int'(cnt[1]);
            S_CNT2:  return int'(cnt[2]);
            default: return int'(rcnt);
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            S_REQ:   return "resync_req";
            S_REP:   return "resync_replica";
            S_BUSY:  return "resync_busy";
            S_FATAL: return "fatal";
            S_CNT0:  return "err_cnt0";
            S_CNT1:  return "err_cnt1";
            S_CNT2:  return "err_cnt2";
            default: return "resync_cnt";
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        int act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    act = get_sig(sb[i].dut, sb[i].sig);
                    checks++;
                    if (sb[i].cyc < cyc || act != sb[i].expv) begin
                        errors++;
                        $display("FAIL dut%0d.%s id=%0d cyc=%0d actual=%0d expected=%0d",
                                 sb[i].dut, sig_name(sb[i].sig), sb[i].id, cyc, act, sb[i].expv);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int d, input int dut, input int sig, input int v);
        exp_t e;
        e.cyc = cyc + d; e.dut = dut; e.sig = sig; e.expv = v; e.id = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic ex_zero(input int dut);
        for (int s = 0; s < 8; s++) ex(0, dut, s, 0);
    endtask

    initial begin
        rst_a = 1; en_a = 0; corr_a = '0; det_a = '0; mm_a = '0; ifa.resync_ack_i = 0;
        rst_b = 1; en_b = 0; corr_b = '0; det_b = '0; mm_b = '0; ifb.resync_ack_i = 0;
        rst_c = 1; en_c = 0; corr_c = '0; det_c = '0; mm_c = '0; ifc.resync_ack_i = 0;
        tick(); tick();
        ex_zero(0); ex_zero(1); ex_zero(2);

        // Threshold crossing and full handshake on replica 2
        rst_a = 0; en_a = 1;
        corr_a = 2'b01; mm_a[0] = 3'b100;
        for (int i = 1; i <= 4; i++) begin
            tick(); ex(0, 0, S_CNT2, i); ex(0, 0, S_REQ, 0);
        end
        corr_a = '0; mm_a = '0;
        tick(); ex(0, 0, S_REQ, 1); ex(0, 0, S_REP, 4); ex(0, 0, S_BUSY, 1);
        repeat (4) begin
            tick(); ex(0, 0, S_REQ, 1); ex(0, 0, S_REP, 4);
        end
        ifa.resync_ack_i = 1; tick(); ifa.resync_ack_i = 0;
        ex(0, 0, S_REQ, 0); ex(0, 0, S_REP, 0); ex(0, 0, S_CNT2, 0);
        for (int i = 0; i < 16; i++) ex(i, 0, S_BUSY, 1);
        ex(15, 0, S_RCNT, 0); ex(16, 0, S_BUSY, 0); ex(16, 0, S_RCNT, 1);
        repeat (16) tick();

        // Two triplets flagging the same replica count once; tie goes to replica 0
        corr_a = 2'b11; mm_a[0] = 3'b001; mm_a[1] = 3'b001;
        tick(); ex(0, 0, S_CNT0, 1);
        corr_a = 2'b01; mm_a[0] = 3'b010; mm_a[1] = 3'b000;
        tick(); ex(0, 0, S_CNT0, 1); ex(0, 0, S_CNT1, 1);
        mm_a[0] = 3'b011;
        repeat (3) tick();
        ex(0, 0, S_CNT0, 4); ex(0, 0, S_CNT1, 4);
        corr_a = '0; mm_a = '0;
        tick(); ex(0, 0, S_REQ, 1); ex(0, 0, S_REP, 1);
        ifa.resync_ack_i = 1; tick(); ifa.resync_ack_i = 0;
        ex(0, 0, S_CNT0, 0); ex(0, 0, S_CNT1, 4);
        ex(16, 0, S_RCNT, 2); ex(17, 0, S_REQ, 1); ex(17, 0, S_REP, 2);
        repeat (17) tick();

        // Fatal beats a same-cycle ack while in REQ; hits ignored afterwards
        det_a = 2'b01; corr_a = 2'b00; ifa.resync_ack_i = 1;
        tick(); ifa.resync_ack_i = 0;
        ex(0, 0, S_FATAL, 1); ex(0, 0, S_REQ, 0); ex(0, 0, S_BUSY, 0); ex(0, 0, S_REP, 0);
        det_a = '0; corr_a = 2'b01; mm_a[0] = 3'b010;
        for (int i = 0; i < 100; i++) begin
            tick(); ex(0, 0, S_FATAL, 1);
        end
        ex(0, 0, S_CNT1, 4); ex(0, 0, S_BUSY, 0); ex(0, 0, S_RCNT, 2);
        corr_a = '0; mm_a = '0;
        rst_a = 1; tick(); rst_a = 0;
        ex_zero(0);

        // Reset while requesting replica 1
        corr_a = 2'b01; mm_a[0] = 3'b010;
        repeat (4) tick();
        ex(0, 0, S_CNT1, 4);
        corr_a = '0; mm_a = '0;
        tick(); ex(0, 0, S_REQ, 1); ex(0, 0, S_REP, 2);
        rst_a = 1; tick(); rst_a = 0;
        ex_zero(0);
        for (int i = 0; i < 10; i++) begin
            tick(); ex(0, 0, S_REQ, 0); ex(0, 0, S_BUSY, 0);
        end

        // Enable gating: hits, fatal patterns and acks all ignored
        corr_a = 2'b01; mm_a[0] = 3'b001;
        repeat (2) tick();
        ex(0, 0, S_CNT0, 2);
        en_a = 0;
        for (int i = 0; i < 50; i++) begin
            corr_a = i[0] ? 2'b11 : 2'b00;
            det_a = 2'b11; mm_a[0] = 3'b111; mm_a[1] = 3'b111;
            ifa.resync_ack_i = i[1];
            tick();
            if (i % 10 == 9) begin
                ex(0, 0, S_CNT0, 2); ex(0, 0, S_FATAL, 0);
            end
        end
        ex(0, 0, S_CNT1, 0); ex(0, 0, S_CNT2, 0); ex(0, 0, S_REQ, 0);
        corr_a = '0; det_a = '0; mm_a = '0; ifa.resync_ack_i = 0;

        // Window of 8: hit on the window's last cycle is lost to the clear
        rst_b = 0; en_b = 1; corr_b = 1'b1; mm_b[0] = 3'b001;
        for (int i = 1; i <= 3; i++) begin
            tick(); ex(0, 1, S_CNT0, i);
        end
        corr_b = 1'b0;
        repeat (4) tick();
        ex(0, 1, S_CNT0, 3);
        corr_b = 1'b1;
        tick(); ex(0, 1, S_CNT0, 0);
        tick(); ex(0, 1, S_CNT0, 1);
        corr_b = 1'b0;

        // Saturation at 15 with a long window
        rst_c = 0; en_c = 1; corr_c = 1'b1; mm_c[0] = 3'b001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            ex(0, 2, S_CNT0, (i > 15) ? 15 : i);
            ex(0, 2, S_REQ, (i >= 16) ? 1 : 0);
        end
        corr_c = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
            errors = errors + sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
